multiplicador_seq_4bits: RTL and testbench

Sequential shift-and-add multiplier-accumulator computing P = A·B + C over WIDTH-bit unsigned operands, one partial product per clock. It is the inverse path of the combinational divider in the arithmetic unit. Fed with quotient, divisor and remainder, it reconstructs the dividend, which lets the self-check logic confirm every division result. It uses a START/BUSY/DONE handshake so the controller can issue operations back-to-back.

---
 rtl/multiplicador_seq_4bits_pkg.sv | 14 +
 rtl/multiplicador_seq_4bits_if.sv | 20 ++
 rtl/multiplicador_seq_4bits_somador.sv | 42 ++++
 rtl/multiplicador_seq_4bits.sv | 102 ++++++++++
 tb/tb_multiplicador_seq_4bits.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/multiplicador_seq_4bits_pkg.sv
// Shared arithmetic-unit definitions: default operand width and opcode set
// used by the multiplier, the divider and the controller.
package multiplicador_seq_4bits_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } opcode_e;

endpackage

// File: rtl/multiplicador_seq_4bits_if.sv
// START/BUSY/DONE operand/result bundle between the controller (master)
// and the sequential multiplier-accumulator (slave).
interface multiplicador_seq_4bits_if #(
  parameter int WIDTH = multiplicador_seq_4bits_pkg::WIDTH_DEF
);

  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   c;
  logic [2*WIDTH-1:0] p;
  logic               busy;
  logic               done;

  modport master (output start, output a, output b, output c,
                  input  p, input busy, input done);
  modport slave  (input  start, input a, input b, input c,
                  output p, output busy, output done);

endinterface

// File: rtl/multiplicador_seq_4bits_somador.sv
// Structural ripple-carry adder built from full adders; the carry out of the
// top bit is dropped because results always fit the adder width.
module somador_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

module somador_nbits #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s
);

  logic [N-1:0] carry_s;

  assign carry_s[0] = cin;

  for (genvar i = 0; i < N - 1; i++) begin : g_fa
    somador_fa u_fa (
      .a (a[i]),
      .b (b[i]),
      .ci(carry_s[i]),
      .s (s[i]),
      .co(carry_s[i+1])
    );
  end

  // MSB: sum only, its carry would leave the result width.
  assign s[N-1] = a[N-1] ^ b[N-1] ^ carry_s[N-1];

endmodule

// File: rtl/multiplicador_seq_4bits.sv
// Sequential shift-and-add multiplier-accumulator, P = A*B + C, one partial
// product per clock; used to rebuild dividends from divider results.
module multiplicador_seq_4bits
  import multiplicador_seq_4bits_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  multiplicador_seq_4bits_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_INC  = CNT_W'(1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] sum_s;
  logic [2*WIDTH-1:0] acc_next_s;

  somador_nbits #(.N(2*WIDTH)) u_somador (
    .a  (acc_q),
    .b  (mcand_q),
    .cin(1'b0),
    .s  (sum_s)
  );

  assign acc_next_s = mplr_q[0] ? sum_s : acc_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          acc_d   = {{WIDTH{1'b0}}, bus.c};
          mcand_d = {{WIDTH{1'b0}}, bus.a};
          mplr_d  = bus.b;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d   = acc_next_s;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + CNT_INC;
        // Last iteration publishes the sum that includes this step's add.
        if (cnt_q == CNT_LAST) begin
          p_d     = acc_next_s;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q == S_RUN);
  assign bus.done = done_q;
  assign bus.p    = p_q;

endmodule

// File: tb/tb_multiplicador_seq_4bits.sv
// Directed bench for multiplicador_seq_4bits: expected products are queued
// when an operation is issued and popped when DONE is observed.
module tb_multiplicador_seq_4bits;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;
  logic [7:0] exp_q[$];
  logic [7:0] last_p;

  multiplicador_seq_4bits_if #(.WIDTH(4)) bus ();

  multiplicador_seq_4bits #(.WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one operation, check BUSY/DONE timing and P against the scoreboard.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input bit keep_start, input bit pulse_mid);
    logic [7:0] exp_p;
    bus.a = a;
    bus.b = b;
    bus.c = c;
    bus.start = 1'b1;
    exp_q.push_back(8'(a) * 8'(b) + 8'(c));
    step();
    if (!keep_start) bus.start = 1'b0;
    bus.a = ~a;
    bus.b = ~b;
    bus.c = ~c;
    for (int i = 0; i < 4; i++) begin
      check("busy_run", 32'(bus.busy), 32'd1);
      check("done_run", 32'(bus.done), 32'd0);
      check("p_hold_run", 32'(bus.p), 32'(last_p));
      if (pulse_mid && i == 1) begin
        bus.a = 4'd15;
        bus.b = 4'd15;
        bus.c = 4'd15;
        bus.start = 1'b1;
      end else if (pulse_mid && i == 2) begin
        bus.start = 1'b0;
      end
      step();
    end
    check("done_pulse", 32'(bus.done), 32'd1);
    check("busy_fall", 32'(bus.busy), 32'd0);
    check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      exp_p = exp_q.pop_front();
      check("p_result", 32'(bus.p), 32'(exp_p));
      last_p = exp_p;
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    last_p       = 8'd0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.a        = 4'd0;
    bus.b        = 4'd0;
    bus.c        = 4'd0;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("rst_p", 32'(bus.p), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
    end

    run_op(4'd13, 4'd11, 4'd0, 1'b0, 1'b0);
    step();
    check("hold_p_143", 32'(bus.p), 32'd143);
    check("hold_done", 32'(bus.done), 32'd0);
    check("hold_busy", 32'(bus.busy), 32'd0);

    run_op(4'd4, 4'd3, 4'd2, 1'b0, 1'b0);
    step();
    run_op(4'd15, 4'd15, 4'd15, 1'b0, 1'b0);
    step();
    run_op(4'd9, 4'd0, 4'd7, 1'b0, 1'b0);
    step();
    run_op(4'd0, 4'd15, 4'd0, 1'b0, 1'b0);
    step();

    // Back-to-back with START held, then a mid-RUN START pulse that must be ignored.
    run_op(4'd2, 4'd3, 4'd1, 1'b1, 1'b0);
    run_op(4'd5, 4'd5, 4'd0, 1'b0, 1'b1);
    step();
    check("no_restart_busy", 32'(bus.busy), 32'd0);
    check("no_restart_p", 32'(bus.p), 32'd25);

    // Abort in the second RUN cycle.
    bus.a = 4'd9;
    bus.b = 4'd9;
    bus.c = 4'd9;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("abort_busy_pre", 32'(bus.busy), 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_p", 32'(bus.p), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    last_p = 8'd0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("abort_no_done", 32'(bus.done), 32'd0);
    end
    run_op(4'd6, 4'd7, 4'd3, 1'b0, 1'b0);
    step();
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
